// File: rtl/sram_mem_stage.sv
// Data-memory controller for the MEM stage: each 32-bit load/store runs as two
// 16-bit accesses to an asynchronous SRAM, stalling the pipeline through `ready`.
module sram_mem_stage #(
   parameter int          HALF_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam int             CNT_W    = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             req;
   logic             in_access;
   logic             phase_last;
   logic             store_p0;
   logic [31:0]      addr_p0;
   logic [31:0]      wdata_p0;
   logic [16:0]      word_idx;
   logic             drive_bus;
   logic [15:0]      dq_out;

   // Byte address relative to the SRAM window, as a 17-bit word index; the
   // subtraction wraps, so addresses below the window alias to the top words.
   function automatic logic [16:0] word_index(input logic [31:0] byte_addr);
      return 17'((byte_addr - BASE_ADDR) >> 2);
   endfunction

   assign req        = MEM_R_EN | MEM_W_EN;
   assign in_access  = (state == LOW) || (state == HIGH);
   assign phase_last = in_access && (cnt == CNT_LAST);
   assign word_idx   = word_index(addr_p0);

   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_DQ   = drive_bus ? dq_out : 16'hzzzz;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if ((state_next != state) || !in_access)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         store_p0 <= 1'b0;
      else if ((state == IDLE) && req)
         store_p0 <= MEM_W_EN;
   end

   // Request capture at IDLE: only these copies are used for the whole access.
   always_ff @(posedge CLK) begin
      if ((state == IDLE) && req) begin
         addr_p0  <= address;
         wdata_p0 <= writeData;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         readData <= '0;
      end else if (!store_p0 && phase_last) begin
         if (state == LOW)
            readData[15:0] <= SRAM_DQ;
         else
            readData[31:16] <= SRAM_DQ;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req) state_next = LOW;
         LOW:     if (phase_last) state_next = HIGH;
         HIGH:    if (phase_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      drive_bus = 1'b0;
      dq_out    = '0;
      case (state)
         IDLE: ready = !req;
         LOW: begin
            SRAM_ADDR = {word_idx, 1'b0};
            SRAM_WE_N = !store_p0;
            SRAM_OE_N = store_p0;
            drive_bus = store_p0;
            dq_out    = wdata_p0[15:0];
         end
         HIGH: begin
            SRAM_ADDR = {word_idx, 1'b1};
            SRAM_WE_N = !store_p0;
            SRAM_OE_N = store_p0;
            drive_bus = store_p0;
            dq_out    = wdata_p0[31:16];
         end
         DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

endmodule

// File: doc/sram_mem_stage.md
# sram_mem_stage

Memory-stage data-memory controller for the 5-stage pipeline. Accepts 32-bit load/store requests from the EXE/MEM boundary, performs each as two sequential 16-bit accesses to an external asynchronous SRAM, and returns the assembled load word. It drives `ready`, which is wired to `freeze_N` of the MEM/WB register and to the freeze of all upstream pipeline registers, stalling the pipeline for the duration of every access.

## Interface
- `HALF_CYCLES`, 2, cycles spent on each 16-bit half access (≥1)
- `BASE_ADDR`, 1024, byte address mapped to SRAM word 0

- `CLK`  in  1  rising-edge clock
- `RST`  in  1  asynchronous, active-high reset
- `MEM_R_EN`  in  1  load request
- `MEM_W_EN`  in  1  store request
- `address`  in  32  byte address (ALU result)
- `writeData`  in  32  store data
- `readData`  out  32  last completed load word
- `ready`  out  1  0 = stall pipeline; 1 = stage may advance
- `SRAM_DQ`  inout  16  SRAM data bus
- `SRAM_ADDR`  out  18  SRAM half-word address
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1  active-low SRAM controls

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If a request is present, latch the op (`MEM_W_EN` has priority over `MEM_R_EN` when both are set), `address` and `writeData`; go to LOW.
  - No request → stay in IDLE.
- LOW / HIGH:
  - Each lasts exactly `HALF_CYCLES` cycles, counted by an internal counter that clears on every state entry.
  - LOW → HIGH, then HIGH → DONE.
- DONE: one cycle, then unconditionally go to IDLE. Requests are not sampled in DONE.
- Word index `w = (addr_latched − BASE_ADDR) >> 2`, 17 bits; upper bits are discarded.
- `SRAM_ADDR = {w, 0}` in LOW and `{w, 1}` in HIGH; it is 0 in IDLE and DONE.
- `SRAM_CE_N`, `SRAM_UB_N` and `SRAM_LB_N` are tied to 0.
- Store:
  - `SRAM_WE_N` = 0 throughout LOW and HIGH.
  - `SRAM_DQ` is driven with `wdata[15:0]` in LOW and `wdata[31:16]` in HIGH.
  - `SRAM_OE_N` = 1.
- Load:
  - `SRAM_OE_N` = 0 in LOW and HIGH; `SRAM_WE_N` = 1.
  - `SRAM_DQ` is high-Z.
  - In the last cycle of LOW, `SRAM_DQ` is captured into `readData[15:0]`; in the last cycle of HIGH, into `readData[31:16]`.
- `SRAM_DQ` is high-Z whenever the block is not in a store LOW/HIGH state.
- `ready` (combinational) = (state == DONE) OR (state == IDLE AND no request).
- `readData` holds its value until the next load overwrites it. A store does not modify it.

## Timing
- Reset values: state IDLE, `readData` = 0, `SRAM_ADDR` = 0, `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_DQ` high-Z.
  - `ready` follows its equation: 1 if no request is present during reset, 0 otherwise.
- Request first seen in IDLE at cycle 0:
  - `ready` = 0 in cycles 0 … 2·`HALF_CYCLES`.
  - `ready` = 1 in cycle 2·`HALF_CYCLES`+1, which is the DONE state. With the default this is cycle 5.
  - The pipeline advances on the clock edge that ends DONE.
- The complete `readData` is valid from the start of DONE. The MEM/WB register samples it at the end of DONE.
- A request held continuously across DONE (new instruction behind it) restarts at IDLE in the following cycle. IDLE is never skipped: there is one stall cycle of IDLE per access, already counted above.
- Inputs may change during LOW/HIGH; only the values latched at IDLE are used.
- Asserting `RST` mid-access aborts immediately and asynchronously:
  - `SRAM_WE_N` returns to 1 and the bus goes high-Z.
  - A partially captured `readData` is cleared to 0.
- With `HALF_CYCLES` = 1, each phase lasts one cycle and `ready` rises in cycle 3.

## Test plan
- Reset with no request → `ready` = 1, `readData` = 0, `SRAM_WE_N` = 1, `SRAM_DQ` = Z, `SRAM_ADDR` = 0.
- Store at `address` = 1028, `writeData` = 0xDEADBEEF:
  - `SRAM_ADDR` = 2 with DQ 0xBEEF for 2 cycles, then `SRAM_ADDR` = 3 with DQ 0xDEAD for 2 cycles, with `SRAM_WE_N` = 0 during both.
  - `ready` = 0 in cycles 0–4 and 1 in cycle 5.
- Load from 1028 with an SRAM model holding that data → `SRAM_OE_N` = 0, `readData` = 0xDEADBEEF in DONE, `ready` timing identical to the store case.
- Back-to-back: a load at 1024 immediately followed by a store at 1032 with request held → second access starts the cycle after DONE; `ready` pattern is 0×5, 1, 0×5, 1. After the store, `readData` still holds the 1024 word.
- Simultaneous `MEM_R_EN` = `MEM_W_EN` = 1 → treated as a store; `SRAM_WE_N` = 0 and `readData` unchanged.
- `RST` asserted in the HIGH state of a store → `SRAM_WE_N` = 1 and DQ = Z within the same cycle, state IDLE, `readData` = 0. After release, a new load completes normally.
